add_sched: RTL
==============

# add_sched

Operand scheduler that sits directly upstream of the pipelined adder. It accepts operand pairs on a valid/ready interface and buffers them in a small FIFO. It issues one pair per cycle to the adder's operand inputs and generates a valid flag aligned with the adder's sum output. Issue is gated by a credit counter, so the sum consumer, which cannot stall the adder, is never overrun.

## Interface
- N, 32, operand width (matches adder N)
- DEPTH, 4, operand FIFO entries; power of two, ≥2
- LAT, 2, adder latency in cycles from op_a/op_b to sum; ≥1
- CREDITS, 4, downstream sum buffer slots; 1..15

Clock and reset: one clock; reset is synchronous and active-high.

- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- in_valid  in  1  operand pair present
- in_ready  out  1  FIFO can accept (= not full)
- in_a  in  N  first operand
- in_b  in  N  second operand
- op_a  out  N  registered operand to adder a
- op_b  out  N  registered operand to adder b
- op_valid  out  1  op_a/op_b hold a new pair this cycle
- sum_valid  out  1  adder sum output is valid this cycle
- credit_return  in  1  consumer freed one slot (single-cycle pulse, one credit per cycle)
- credits  out  4  credits available
- fifo_count  out  $clog2(DEPTH)+1  FIFO occupancy
- idle  out  1  FIFO empty, op_valid low, no sum in flight
- credit_err  out  1  sticky: credit returned while credits == CREDITS

## Operation
- **Push:** a push occurs when in_valid && in_ready. Pairs are stored in order. in_ready is registered-state combinational: !full.
- **Issue condition:** FIFO not empty && (credits > 0).
- **On issue:** pop the head, op_a/op_b <= head, op_valid <= 1, consume one credit.
- **No issue:** op_valid <= 0; op_a/op_b hold their last value.
- **Valid tracking:** a LAT-stage shift register carries op_valid. sum_valid is the LAT-th stage.
- **Credit update:** credits_next = credits − issue + (credit_return && credits_eff < CREDITS).
  - Issue and return in the same cycle leaves credits unchanged.
  - A return while credits == CREDITS with no issue is dropped, and credit_err is set. credit_err clears only on reset.
- **FIFO boundary cases:**
  - Push and pop in the same cycle are allowed at any occupancy except full. When full, in_ready = 0, so no push occurs.
  - There is no bypass. A push into an empty FIFO becomes visible next cycle.
  - Read and write pointers wrap modulo DEPTH. fifo_count distinguishes full from empty.
- **Credits exhausted:** the FIFO holds its contents and op_valid drops the cycle after the last credit is used. Issue resumes the cycle after credit_return raises credits above 0.
- **Reset values:**
  - FIFO empty; fifo_count = 0; in_ready = 1.
  - credits = CREDITS.
  - op_a = op_b = 0; op_valid = 0; shift register cleared; sum_valid = 0.
  - credit_err = 0; idle = 1.
- **Reset mid-operation:** reset discards all buffered and in-flight pairs. No sum_valid is produced for them.

## Timing
- Push at edge k → the FIFO entry is visible after edge k. Earliest issue is at edge k+1, so op_valid is high in the cycle after edge k+1.
- Minimum latency from in_valid to op_valid is 2 cycles.
- op_valid high in cycle c → sum_valid high in cycle c+LAT, aligned with the adder's registered sum.
- Throughput: 1 pair/cycle while the FIFO is non-empty and credits > 0.
- A credit_return at edge k takes effect in the issue decision at edge k+1.
- All outputs are registered except in_ready, idle and fifo_count, which are derived from registered state only.

## Structure
- **Shared package add_pkg:**
  - CREDIT_W = 4.
  - Default N/LAT constants shared with the adder, so LAT tracks the adder's pipeline depth in one place.
- **Sub-module add_fifo:** synchronous FIFO with parameters N2 = 2N and DEPTH.
  - Ports: push, pop, din, dout (head, show-ahead), full, empty, count.
- The credit counter and valid shift register live in add_sched.

## Test plan
- **Reset, then 3 pushes on consecutive cycles** (a=1,2,3; b=10,20,30): op_valid high on 3 consecutive cycles with op_a/op_b = (1,10),(2,20),(3,30). sum_valid follows each LAT=2 cycles later. Credits reach 1.
- **Credit stall:** push 6 pairs with no credit_return. Exactly 4 issue and credits = 0. fifo_count reaches 2 and stays there. One credit_return pulse releases exactly one more issue the next cycle.
- **Full FIFO:** hold credits at 0 and push 5 pairs. in_ready drops after the 4th, the 5th is not accepted, and fifo_count = 4. The 4 stored pairs later issue in order.
- **Simultaneous events:** issue and credit_return in the same cycle leaves credits unchanged. credit_return at credits = 4 sets credit_err = 1 and leaves credits = 4.
- **Reset mid-stream:** reset with 2 pairs buffered and 2 in flight. The next cycle shows op_valid = 0, no sum_valid afterwards, fifo_count = 0, credits = 4, idle = 1.
- **Wrap-around:** feed 20 pairs with a credit_return each cycle, matching the sum_valid pulses. All 20 issue in order at 1/cycle with no bubble after the fill-up.

Source files
------------

// File: rtl/add_pkg.sv
// Constants shared between the adder and its operand scheduler.
package add_pkg;

  localparam int ADD_N    = 32;
  localparam int ADD_LAT  = 2;
  localparam int CREDIT_W = 4;

endpackage

// File: rtl/add_fifo.sv
// Show-ahead synchronous FIFO holding packed operand pairs.
module add_fifo #(
  parameter int N2    = 64,
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   push,
  input  logic                   pop,
  input  logic [N2-1:0]          din,
  output logic [N2-1:0]          dout,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [N2-1:0] r_mem [DEPTH];
  logic [AW-1:0] r_wp;
  logic [AW-1:0] r_rp;
  logic [CW-1:0] r_cnt;
  logic          w_push;
  logic          w_pop;

  assign full   = (r_cnt == CW'(DEPTH));
  assign empty  = (r_cnt == '0);
  assign w_push = push && !full;
  assign w_pop  = pop && !empty;
  assign dout   = r_mem[r_rp];
  assign count  = r_cnt;

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wp] <= din;
  end

  // pointers wrap naturally since DEPTH is a power of two
  always_ff @(posedge clk) begin
    if (reset) begin
      r_wp  <= '0;
      r_rp  <= '0;
      r_cnt <= '0;
    end else begin
      if (w_push) r_wp <= r_wp + 1'b1;
      if (w_pop)  r_rp <= r_rp + 1'b1;
      r_cnt <= r_cnt + CW'(w_push) - CW'(w_pop);
    end
  end

endmodule

// File: rtl/add_sched.sv
// Credit-gated operand scheduler feeding the pipelined adder.
module add_sched
  import add_pkg::*;
#(
  parameter int N       = ADD_N,
  parameter int DEPTH   = 4,
  parameter int LAT     = ADD_LAT,
  parameter int CREDITS = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [N-1:0]           in_a,
  input  logic [N-1:0]           in_b,
  output logic [N-1:0]           op_a,
  output logic [N-1:0]           op_b,
  output logic                   op_valid,
  output logic                   sum_valid,
  input  logic                   credit_return,
  output logic [CREDIT_W-1:0]    credits,
  output logic [$clog2(DEPTH):0] fifo_count,
  output logic                   idle,
  output logic                   credit_err
);

  localparam logic [CREDIT_W-1:0] CMAX =
    CREDIT_W'(CREDITS);

  logic                w_full;
  logic                w_empty;
  logic                w_issue;
  logic                w_ret;
  logic [2*N-1:0]      w_head;
  logic [CREDIT_W-1:0] w_eff;

  logic [CREDIT_W-1:0] r_credits;
  logic                r_op_valid;
  logic                r_err;
  logic [N-1:0]        r_op_a;
  logic [N-1:0]        r_op_b;
  logic [LAT-1:0]      r_vsr;

  add_fifo #(
    .N2    (2*N),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (in_valid),
    .pop   (w_issue),
    .din   ({in_a, in_b}),
    .dout  (w_head),
    .full  (w_full),
    .empty (w_empty),
    .count (fifo_count)
  );

  assign w_issue = !w_empty && (r_credits != '0);
  assign w_eff   = r_credits - CREDIT_W'(w_issue);
  // a return that would overflow the pool is dropped
  assign w_ret   = credit_return && (w_eff < CMAX);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_credits  <= CMAX;
      r_op_valid <= 1'b0;
      r_err      <= 1'b0;
      r_op_a     <= '0;
      r_op_b     <= '0;
      r_vsr      <= '0;
    end else begin
      r_op_valid <= w_issue;
      if (w_issue) {r_op_a, r_op_b} <= w_head;
      r_vsr     <= (r_vsr << 1) | LAT'(r_op_valid);
      r_credits <= w_eff + CREDIT_W'(w_ret);
      if (credit_return && !w_ret) r_err <= 1'b1;
    end
  end

  assign in_ready   = !w_full;
  assign op_a       = r_op_a;
  assign op_b       = r_op_b;
  assign op_valid   = r_op_valid;
  assign sum_valid  = r_vsr[LAT-1];
  assign credits    = r_credits;
  assign credit_err = r_err;
  assign idle       = w_empty && !r_op_valid
                      && (r_vsr == '0);

endmodule
